pipe_dff_bank: RTL and testbench

Parametrised multi-channel register pipeline for the CNN datapath. It delays CHANNELS signed lanes by DEPTH stages and carries a valid/ready handshake. Each stage holds its own valid bit, so back-pressure collapses bubbles instead of stalling the whole chain. It sits between convolution/pooling stages wherever timing needs retiming registers, and replaces hand-chained single-word enable registers.

---
 rtl/pipe_dff_bank_pkg.sv | 29 ++
 rtl/pipe_dff_bank_if.sv | 41 ++++
 rtl/pipe_dff_bank_stage.sv | 65 ++++++
 rtl/pipe_dff_bank.sv | 101 ++++++++++
 tb/tb_pipe_dff_bank.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_dff_bank_pkg.sv
// -----------------------------------------------------------------------------
// pipe_dff_bank_pkg
// Shared CNN datapath package. It holds the default lane geometry used by the
// conv/pool stages, the default retiming depth, and helpers that pack signed
// lanes into a flat bus or pull them back out.
// Lane c of a packed word lives at bits [c*DATA_WIDTH +: DATA_WIDTH].
// -----------------------------------------------------------------------------
package pipe_dff_bank_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_CHANNELS   = 4;
   localparam int DEF_DEPTH      = 3;
   localparam int DEF_CNT_W      = $clog2(DEF_DEPTH + 1);

   typedef logic signed [DEF_DATA_WIDTH-1:0] lane_t;
   // A packed array with the index running [CH-1:0] puts lane 0 in the LSBs.
   // That matches the flat bus layout exactly.
   typedef lane_t [DEF_CHANNELS-1:0] lanes_t;

   function automatic logic [DEF_CHANNELS*DEF_DATA_WIDTH-1:0] pack_lanes(input lanes_t l);
      return l;
   endfunction

   function automatic lane_t get_lane(input logic [DEF_CHANNELS*DEF_DATA_WIDTH-1:0] word,
                                      input int c);
      return word[c*DEF_DATA_WIDTH +: DEF_DATA_WIDTH];
   endfunction

endpackage

// File: rtl/pipe_dff_bank_if.sv
// -----------------------------------------------------------------------------
// pipe_dff_bank_if
// Bus bundle for pipe_dff_bank: the upstream and downstream handshakes, the
// data buses and the occupancy count.
//
// Handshake: a word moves across a side on a rising clock edge exactly when
// that side's valid and ready are both high in the preceding cycle. Valid must
// not depend on ready. in_ready is combinational from out_ready, so a stalled
// bank frees its input in the same cycle the downstream starts accepting.
//
//   in_valid  / in_data   : upstream word (master -> bank)
//   in_ready              : bank can take a word this cycle (bank -> master)
//   out_valid / out_data  : word in the last stage (bank -> master)
//   out_ready             : downstream accepts (master -> bank)
//   occupancy             : number of valid stages (bank -> master)
// -----------------------------------------------------------------------------
interface pipe_dff_bank_if
   import pipe_dff_bank_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CHANNELS   = DEF_CHANNELS,
   parameter int CNT_W      = DEF_CNT_W
);
   logic                           in_valid;
   logic                           in_ready;
   logic [CHANNELS*DATA_WIDTH-1:0] in_data;
   logic                           out_valid;
   logic                           out_ready;
   logic [CHANNELS*DATA_WIDTH-1:0] out_data;
   logic [CNT_W-1:0]               occupancy;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, occupancy
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, occupancy
   );
endinterface

// File: rtl/pipe_dff_bank_stage.sv
// -----------------------------------------------------------------------------
// pipe_dff_stage
// One retiming stage. It holds a valid bit and a data word, and produces its
// own ready term.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : global enable; low freezes the stage
//   flush_i       : synchronous clear (only when en_i is high)
//   src_vld_i/_dat_i : upstream stage (or bank input)
//   down_rdy_i    : ready of the downstream stage (or out_ready)
//   vld_o, dat_o  : registered stage contents
//   rdy_o         : stage may load this cycle (empty or draining)
// -----------------------------------------------------------------------------
module pipe_dff_stage
   import pipe_dff_bank_pkg::*;
#(
   parameter int W = DEF_CHANNELS * DEF_DATA_WIDTH
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   input  logic         flush_i,
   input  logic         src_vld_i,
   input  logic [W-1:0] src_dat_i,
   input  logic         down_rdy_i,
   output logic         vld_o,
   output logic [W-1:0] dat_o,
   output logic         rdy_o
);
   logic         vld_q, vld_d;
   logic [W-1:0] dat_q, dat_d;

   // An empty stage always loads. This is what collapses bubbles while the
   // downstream is stalled.
   assign rdy_o = down_rdy_i | ~vld_q;

   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (en_i) begin
         if (flush_i) begin
            vld_d = 1'b0;
            dat_d = '0;
         end else if (rdy_o) begin
            vld_d = src_vld_i;
            // Data only follows a valid source; stale data is don't-care.
            if (src_vld_i) begin
               dat_d = src_dat_i;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= 1'b0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   assign vld_o = vld_q;
   assign dat_o = dat_q;
endmodule

// File: rtl/pipe_dff_bank.sv
// -----------------------------------------------------------------------------
// pipe_dff_bank
// DEPTH-stage retiming pipeline for CHANNELS signed lanes, with a valid/ready
// handshake. Each stage has its own valid bit, so back-pressure squeezes out
// bubbles instead of stalling the whole chain. Data passes through unmodified.
//   clk_i   : rising-edge clock
//   rst_ni  : asynchronous active-low reset
//   en_i    : global enable; low freezes all state and ignores flush
//   flush_i : synchronous clear of every stage and of the occupancy count
//   bus_if  : pipe_dff_bank_if.slave (handshakes, data, occupancy)
// -----------------------------------------------------------------------------
module pipe_dff_bank
   import pipe_dff_bank_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CHANNELS   = DEF_CHANNELS,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           en_i,
   input  logic           flush_i,
   pipe_dff_bank_if.slave bus_if
);
   localparam int W = CHANNELS * DATA_WIDTH;

   logic             in_acc;
   logic             out_acc;
   logic [CNT_W-1:0] occ_q, occ_d;

   // Ready is a purely combinational chain from out_ready back to stage 0.
   // Each stage's signals live in their own generate scope.
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic         vld;
      logic         rdy;
      logic         src_vld;
      logic         down_rdy;
      logic [W-1:0] dat;
      logic [W-1:0] src_dat;

      if (i == 0) begin : g_src_in
         assign src_vld = bus_if.in_valid;
         assign src_dat = bus_if.in_data;
      end else begin : g_src_prev
         assign src_vld = g_stage[i-1].vld;
         assign src_dat = g_stage[i-1].dat;
      end

      if (i == DEPTH - 1) begin : g_dn_out
         assign down_rdy = bus_if.out_ready;
      end else begin : g_dn_next
         assign down_rdy = g_stage[i+1].rdy;
      end

      pipe_dff_stage #(.W(W)) u_stage (
         .clk_i      (clk_i),
         .rst_ni     (rst_ni),
         .en_i       (en_i),
         .flush_i    (flush_i),
         .src_vld_i  (src_vld),
         .src_dat_i  (src_dat),
         .down_rdy_i (down_rdy),
         .vld_o      (vld),
         .dat_o      (dat),
         .rdy_o      (rdy)
      );
   end

   assign bus_if.in_ready  = en_i & ~flush_i & g_stage[0].rdy;
   assign bus_if.out_valid = en_i & g_stage[DEPTH-1].vld;
   assign bus_if.out_data  = g_stage[DEPTH-1].dat;

   // out_valid still shows during a flush, but flush wins. The word is not
   // counted as leaving.
   assign in_acc  = bus_if.in_valid & bus_if.in_ready;
   assign out_acc = bus_if.out_valid & bus_if.out_ready & ~flush_i;

   // Tracking accept events keeps the count equal to popcount(vld) without
   // an adder tree over the valid bits.
   always_comb begin
      occ_d = occ_q;
      if (en_i && flush_i) begin
         occ_d = '0;
      end else if (in_acc && !out_acc) begin
         occ_d = occ_q + CNT_W'(1);
      end else if (out_acc && !in_acc) begin
         occ_d = occ_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign bus_if.occupancy = occ_q;
endmodule

// File: tb/tb_pipe_dff_bank.sv
// -----------------------------------------------------------------------------
// tb_pipe_dff_bank
// Directed scenarios followed by a randomized stretch, all checked against a
// word-queue reference. Each queued word carries its position in the
// pipeline. Each enabled cycle the oldest word leaves if it is at the end and
// out_ready is high. Every other word then advances one slot if that slot has
// been vacated.
// -----------------------------------------------------------------------------
module tb_pipe_dff_bank;
   import pipe_dff_bank_pkg::*;

   localparam int DW    = 8;
   localparam int CH    = 4;
   localparam int DEPTH = 3;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int W     = DW * CH;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic en    = 1'b0;
   logic flush = 1'b0;

   pipe_dff_bank_if #(.DATA_WIDTH(DW), .CHANNELS(CH), .CNT_W(CNT_W)) bus ();

   pipe_dff_bank #(.DATA_WIDTH(DW), .CHANNELS(CH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .en_i    (en),
      .flush_i (flush),
      .bus_if  (bus)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard ----------------
   int         total = 0;
   int         bad   = 0;
   logic [W-1:0] exp_q[$];
   int           pos_q[$];
   logic         last_acc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      pos_q.delete();
   endtask

   // One clock: check outputs at the falling edge, advance the reference, then
   // return 1 time unit after the rising edge so the caller can drive the next
   // inputs.
   task automatic cyc();
      int   limit;
      logic exp_ir;
      last_acc = 1'b0;
      @(negedge clk);
      check("occupancy", 64'(bus.occupancy), 64'(exp_q.size()));
      if (exp_q.size() > 0 && pos_q[0] == DEPTH - 1) begin
         check("out_data", bus.out_data, exp_q[0]);
         check("out_valid", bus.out_valid, en);
      end else begin
         check("out_valid", bus.out_valid, 0);
      end
      if (!en) begin
         check("in_ready_dis", bus.in_ready, 0);
      end else if (flush) begin
         check("in_ready_flush", bus.in_ready, 0);
         model_clear();
      end else begin
         if (exp_q.size() > 0 && pos_q[0] == DEPTH - 1 && bus.out_ready) begin
            void'(exp_q.pop_front());
            void'(pos_q.pop_front());
         end
         limit = DEPTH;
         foreach (pos_q[i]) begin
            if (pos_q[i] + 1 < limit) pos_q[i]++;
            limit = pos_q[i];
         end
         exp_ir = (pos_q.size() == 0) || (pos_q[pos_q.size()-1] > 0);
         check("in_ready", bus.in_ready, exp_ir);
         if (exp_ir && bus.in_valid) begin
            exp_q.push_back(bus.in_data);
            pos_q.push_back(0);
            last_acc = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- drivers ----------------
   task automatic send(input logic [W-1:0] w);
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      cyc();
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] w1;
      logic [W-1:0] wa, wb;
      logic [W-1:0] w5[5];
      logic [W-1:0] lane_word;
      int           idx;
      int           lanes[CH];

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      en            = 1'b1;

      // Reset: the outputs follow immediately, before any clock edge.
      #1 rst_n = 1'b0;
      #2;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_occupancy", bus.occupancy, 0);
      check("rst_in_ready", bus.in_ready, 1);
      #9 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single word with lanes {-1, 2, -128, 127}, latency DEPTH.
      lanes = '{-1, 2, -128, 127};
      w1 = '0;
      for (int c = 0; c < CH; c++) begin
         lane_word = W'(lanes[c] & 32'hFF);
         w1 = w1 | (lane_word << (c * DW));
      end
      check("t1_pack", w1, 32'h7F80_02FF);
      send(w1);
      check("t1_lat0", bus.out_valid, 0);
      cyc();
      check("t1_lat1", bus.out_valid, 0);
      cyc();
      check("t1_out_valid", bus.out_valid, 1);
      check("t1_out_data", bus.out_data, 32'h7F80_02FF);
      cyc();
      check("t1_empty", bus.occupancy, 0);
      check("t1_out_gone", bus.out_valid, 0);

      // Back-pressure: five words, only DEPTH fit.
      foreach (w5[i]) w5[i] = W'($urandom);
      bus.out_ready = 1'b0;
      idx = 0;
      for (int k = 0; k < 4; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = w5[idx];
         cyc();
         if (last_acc) idx++;
      end
      check("t2_full_in_ready", bus.in_ready, 0);
      check("t2_full_occ", bus.occupancy, 3);
      check("t2_full_head", bus.out_data, w5[0]);
      bus.out_ready = 1'b1;
      #1;
      check("t2_release_in_ready", bus.in_ready, 1);
      for (int k = 0; k < 20 && idx < 5; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = w5[idx];
         cyc();
         if (last_acc) idx++;
      end
      check("t2_all_accepted", idx, 5);
      bus.in_valid = 1'b0;
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) cyc();
      check("t2_drained", bus.occupancy, 0);

      // Bubble collapse under a stall.
      wa = W'($urandom);
      wb = W'($urandom);
      bus.out_ready = 1'b0;
      send(wa);
      idle(2);
      send(wb);
      idle(1);
      check("t3_occ", bus.occupancy, 2);
      check("t3_out_valid", bus.out_valid, 1);
      check("t3_head", bus.out_data, wa);
      bus.out_ready = 1'b1;
      cyc();
      check("t3_second_valid", bus.out_valid, 1);
      check("t3_second_data", bus.out_data, wb);
      cyc();
      check("t3_empty", bus.occupancy, 0);

      // Flush while both sides could transfer.
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) send(W'($urandom));
      bus.in_valid  = 1'b1;
      bus.in_data   = W'($urandom);
      bus.out_ready = 1'b1;
      flush         = 1'b1;
      #1;
      check("t4_flush_in_ready", bus.in_ready, 0);
      check("t4_flush_out_valid", bus.out_valid, 1);
      cyc();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      check("t4_occ", bus.occupancy, 0);
      check("t4_out_valid", bus.out_valid, 0);
      check("t4_out_data", bus.out_data, 0);
      idle(3);

      // Enable low mid-stream freezes everything.
      wa = W'($urandom);
      wb = W'($urandom);
      bus.out_ready = 1'b1;
      send(wa);
      send(wb);
      en           = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = W'($urandom);
      for (int k = 0; k < 4; k++) begin
         cyc();
         check("t5_frz_in_ready", bus.in_ready, 0);
         check("t5_frz_out_valid", bus.out_valid, 0);
         check("t5_frz_occ", bus.occupancy, 2);
      end
      en           = 1'b1;
      bus.in_valid = 1'b0;
      cyc();
      check("t5_resume_a_valid", bus.out_valid, 1);
      check("t5_resume_a_data", bus.out_data, wa);
      cyc();
      check("t5_resume_b_valid", bus.out_valid, 1);
      check("t5_resume_b_data", bus.out_data, wb);
      cyc();
      check("t5_empty", bus.occupancy, 0);

      // Asynchronous reset between edges while two words are in flight.
      bus.out_ready = 1'b0;
      send(W'($urandom));
      send(W'($urandom));
      idle(1);
      check("t6_pre_occ", bus.occupancy, 2);
      check("t6_pre_out_valid", bus.out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_out_valid", bus.out_valid, 0);
      check("t6_rst_occ", bus.occupancy, 0);
      check("t6_rst_out_data", bus.out_data, 0);
      check("t6_rst_in_ready", bus.in_ready, 1);
      model_clear();
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc();
         check("t6_no_stale", bus.out_valid, 0);
      end

      // Randomized traffic with stalls, disables and occasional flushes.
      for (int k = 0; k < 400; k++) begin
         en            = ($urandom_range(0, 9) != 0);
         flush         = ($urandom_range(0, 29) == 0);
         bus.in_valid  = $urandom_range(0, 1) == 1;
         bus.in_data   = W'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end
      en            = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) cyc();
      check("rand_drained", bus.occupancy, 0);
      check("rand_no_valid", bus.out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
